dlatch_bank: RTL and testbench
==============================

# dlatch_bank

Parametrised multi-channel D storage bank: the successor to the single-bit gated D latch. Holds CHANNELS independent WIDTH-bit values, each with its own load enable and synchronous clear. The storage mode is selectable between a transparent latch and an edge-triggered register. Adds per-channel change detection, saturating change counters and a global freeze, so board-level demos and larger datapaths can use one block instead of many hand-wired latches.

## Interface
- WIDTH, default 1: bits per channel (1..32)
- CHANNELS, default 4: number of channels (1..16)
- TRANSPARENT, default 1: 1 = latch mode (q follows d while enabled); 0 = edge-register mode
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- d  input  CHANNELS*WIDTH  data in, channel i at bits [i*WIDTH +: WIDTH]
- en  input  CHANNELS  per-channel load/gate enable
- clr  input  CHANNELS  per-channel synchronous clear
- freeze  input  1  global hold; masks all en, does not mask clr
- q  output  CHANNELS*WIDTH  stored/visible value
- q_n  output  CHANNELS*WIDTH  bitwise complement of q, always
- changed  output  CHANNELS  one-cycle pulse per channel when its stored value changed
- cnt_sel  input  max(1,$clog2(CHANNELS))  counter read select
- cnt_out  output  8  change count of the selected channel

## Operation
- Per channel: state register `st[i]` (WIDTH bits); effective enable `ge[i] = en[i] & ~freeze`.
- Next state: rst → 0; else clr[i] → 0; else ge[i] → d[i]; else hold. Priority is rst > clr > ge.
- Edge mode (TRANSPARENT=0): q[i] = st[i]. Pure register, no combinational path from d to q.
- Latch mode (TRANSPARENT=1): combinational view. If rst or clr[i], q[i] = 0. Else if ge[i], q[i] = d[i]. Else q[i] = st[i]. The value present at the edge is the one retained when ge drops.
- q_n = ~q in both modes. It includes the transparent path.
- changed[i] is a registered output, `changed[i] <= (st_next[i] != st[i])`, and is forced 0 under rst. A clr that zeroes a nonzero value counts as a change. Reloading an identical value does not.
- Counter cnt[i] is 8 bits. It increments on each cycle where changed[i] would be set, and saturates at 255. Only rst zeroes it; clr does not.
- cnt_out = cnt[cnt_sel], combinational. A cnt_sel ≥ CHANNELS yields 0.

## Timing
- Reset values: st = 0, q = 0, q_n = all ones, changed = 0, cnt = 0, cnt_out = 0.
- Edge mode latency: d to q is 1 cycle.
- Latch mode latency: d to q is 0 cycles while enabled.
- changed asserts the cycle after the edge that updated st. It lasts exactly 1 cycle per change. Consecutive changes give consecutive pulses.
- The counter reflects a change in the same cycle changed pulses.
- Simultaneous clr and en: clr wins, and q = 0 in both modes (in latch mode, 0 immediately).
- freeze asserted mid-transparency: q immediately shows st, i.e. the value captured at the last edge.
- rst asserted mid-operation: all state clears at the next edge. In latch mode q reads 0 combinationally while rst is high. No partial update of counters.
- Counter at 255 with a further change: changed still pulses and cnt stays 255.

## Structure
- Package dlatch_bank_pkg holds:
  - CNT_W = 8 and CNT_MAX = 255
  - MODE_EDGE = 0 and MODE_TRANSPARENT = 1
  - a function for the select width, max(1,$clog2(n))
- Sub-module dlatch_cell covers one channel: st register, transparent mux, change compare, saturating counter. It is instantiated CHANNELS times by a generate loop.
- The top level contains only freeze gating, the flat-bus slicing and the cnt_out mux.

## Test plan
- Edge mode, WIDTH=4, CHANNELS=4: d ch1 = 0xA with en[1]=1 for one cycle → q ch1 = 0xA one cycle later, q_n ch1 = 0x5, changed[1] pulses once, cnt_out (sel=1) = 1.
- Latch mode: en[0]=1 and d toggles 0x3→0xC within the enable window → q follows with 0 latency. en drops with d=0xC → q holds 0xC while d changes to 0x1.
- clr[2] and en[2] together with d=0xF while ch2 holds 0x7 → q ch2 = 0, changed[2] pulses, cnt increments. A repeated clr on the zero value → no pulse.
- freeze=1 with en all high and new d → q unchanged and no changed pulses. Latch mode shows st, not d. clr[0] during freeze still zeroes ch0.
- 300 alternating loads on ch3 → cnt_out = 255 and saturates. Then rst → all q = 0, q_n all ones, cnt_out = 0. cnt_sel = CHANNELS (when CHANNELS is not a power of two, e.g. 3) → cnt_out = 0.

Source files
------------

// File: rtl/dlatch_bank_pkg.sv
// dlatch_bank_pkg: shared constants and helpers for the dlatch_bank slice.
//   CNT_W / CNT_MAX : width and saturation value of the per-channel change counters
//   mode_e          : storage mode encoding (edge register or transparent latch)
//   sel_width()     : counter-select width, max(1, $clog2(n))
package dlatch_bank_pkg;

   localparam int unsigned     CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

   typedef enum logic {
      MODE_EDGE        = 1'b0,
      MODE_TRANSPARENT = 1'b1
   } mode_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dlatch_bank_if.sv
// dlatch_bank_if: data/control bundle of the storage bank.
//   d, en, clr, freeze, cnt_sel : driven by the master (system side)
//   q, q_n, changed, cnt_out    : driven by the bank (slave side)
interface dlatch_bank_if #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 4
);
   import dlatch_bank_pkg::*;

   localparam int unsigned SEL_W = sel_width(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] d;
   logic [CHANNELS-1:0]       en;
   logic [CHANNELS-1:0]       clr;
   logic                      freeze;
   logic [SEL_W-1:0]          cnt_sel;
   logic [CHANNELS*WIDTH-1:0] q;
   logic [CHANNELS*WIDTH-1:0] q_n;
   logic [CHANNELS-1:0]       changed;
   logic [CNT_W-1:0]          cnt_out;

   modport master (
      output d, en, clr, freeze, cnt_sel,
      input  q, q_n, changed, cnt_out
   );

   modport slave (
      input  d, en, clr, freeze, cnt_sel,
      output q, q_n, changed, cnt_out
   );

endinterface

// File: rtl/dlatch_cell.sv
// dlatch_cell: one storage channel.
//   clk, rst : clock, synchronous active-high reset
//   d        : channel data in
//   ge       : effective load enable (freeze already applied)
//   clr      : synchronous clear, beats ge
//   q        : visible value (transparent or registered view of st)
//   changed  : registered pulse when st changed at the last edge
//   cnt      : saturating count of changes, cleared only by rst
module dlatch_cell
   import dlatch_bank_pkg::*;
#(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned TRANSPARENT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             ge,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             changed,
   output logic [CNT_W-1:0] cnt
);

   localparam bit LATCH = (TRANSPARENT != 0);

   logic [WIDTH-1:0] st;
   logic [WIDTH-1:0] st_next;
   logic             diff;

   always_comb begin
      st_next = st;
      if (rst || clr) st_next = '0;
      else if (ge)    st_next = d;
   end

   assign diff = (st_next != st);

   always_ff @(posedge clk) begin
      st <= st_next;
      if (rst) begin
         changed <= 1'b0;
         cnt     <= '0;
      end else begin
         changed <= diff;
         if (diff && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
      end
   end

   if (LATCH == bit'(MODE_TRANSPARENT)) begin : g_latch
      // Same priority as st_next, so q shows what the next edge will keep.
      always_comb begin
         q = st;
         if (rst || clr) q = '0;
         else if (ge)    q = d;
      end
   end else begin : g_edge
      assign q = st;
   end

endmodule

// File: rtl/dlatch_bank.sv
// dlatch_bank: CHANNELS independent WIDTH-bit storage cells with per-channel
// clear, change pulses and saturating change counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dlatch_bank_if slave (d/en/clr/freeze/cnt_sel in; q/q_n/changed/cnt_out out)
module dlatch_bank
   import dlatch_bank_pkg::*;
#(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned TRANSPARENT = 1
) (
   input  logic         clk,
   input  logic         rst,
   dlatch_bank_if.slave bus
);

   logic [CHANNELS-1:0] ge;
   logic [CNT_W-1:0]    cnt [CHANNELS];

   // freeze masks loads only; clears still reach the cells.
   assign ge = bus.en & ~{CHANNELS{bus.freeze}};

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      dlatch_cell #(
         .WIDTH       (WIDTH),
         .TRANSPARENT (TRANSPARENT)
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .d       (bus.d[i*WIDTH +: WIDTH]),
         .ge      (ge[i]),
         .clr     (bus.clr[i]),
         .q       (bus.q[i*WIDTH +: WIDTH]),
         .changed (bus.changed[i]),
         .cnt     (cnt[i])
      );
   end

   assign bus.q_n = ~bus.q;

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      bus.cnt_out = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (32'(bus.cnt_sel) == i) bus.cnt_out = cnt[i];
      end
   end

endmodule

// File: tb/tb_dlatch_bank.sv
module tb_dlatch_bank;

   localparam int unsigned W = 4;
   localparam int unsigned C = 4;

   typedef struct packed {
      logic [C*W-1:0] qe;
      logic [C*W-1:0] ql;
      logic [C-1:0]   chg;
      logic [7:0]     cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [C*W-1:0] r_d      = '0;
   logic [C-1:0]   r_en     = '0;
   logic [C-1:0]   r_clr    = '0;
   logic           r_freeze = 1'b0;
   logic [1:0]     r_sel    = '0;

   logic [3*W-1:0] r3_d   = '0;
   logic [2:0]     r3_en  = '0;
   logic [1:0]     r3_sel = '0;

   logic [W-1:0] m_st  [C];
   int unsigned  m_cnt [C];
   exp_t         sb [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dlatch_bank_if #(.WIDTH(W), .CHANNELS(C)) ife ();
   dlatch_bank_if #(.WIDTH(W), .CHANNELS(C)) ifl ();
   dlatch_bank_if #(.WIDTH(W), .CHANNELS(3)) if3 ();

   assign ife.d = r_d;  assign ife.en = r_en;  assign ife.clr = r_clr;
   assign ife.freeze = r_freeze;  assign ife.cnt_sel = r_sel;
   assign ifl.d = r_d;  assign ifl.en = r_en;  assign ifl.clr = r_clr;
   assign ifl.freeze = r_freeze;  assign ifl.cnt_sel = r_sel;
   assign if3.d = r3_d;  assign if3.en = r3_en;  assign if3.clr = '0;
   assign if3.freeze = 1'b0;  assign if3.cnt_sel = r3_sel;

   dlatch_bank #(.WIDTH(W), .CHANNELS(C), .TRANSPARENT(0)) dut_e (.clk(clk), .rst(rst), .bus(ife.slave));
   dlatch_bank #(.WIDTH(W), .CHANNELS(C), .TRANSPARENT(1)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));
   dlatch_bank #(.WIDTH(W), .CHANNELS(3), .TRANSPARENT(0)) dut_3 (.clk(clk), .rst(rst), .bus(if3.slave));

   // Advance one clock: predict from the current inputs, push, then pop and compare after the edge.
   task automatic cycle();
      exp_t        e;
      logic [W-1:0] nxt, dd;
      logic        ge;
      for (int i = 0; i < int'(C); i++) begin
         ge = r_en[i] & ~r_freeze;
         dd = r_d[i*W +: W];
         if (rst)           nxt = '0;
         else if (r_clr[i]) nxt = '0;
         else if (ge)       nxt = dd;
         else               nxt = m_st[i];
         e.chg[i] = !rst && (nxt != m_st[i]);
         if (rst) m_cnt[i] = 0;
         else if (e.chg[i] && m_cnt[i] < 255) m_cnt[i]++;
         m_st[i] = nxt;
         e.qe[i*W +: W] = nxt;
         e.ql[i*W +: W] = (rst || r_clr[i]) ? '0 : (ge ? dd : nxt);
      end
      e.cnt = 8'(m_cnt[r_sel]);
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks += 8;
      if (ife.q !== e.qe)        begin errors++; $display("FAIL edge_q got %h want %h t=%0t", ife.q, e.qe, $time); end
      if (ife.q_n !== ~e.qe)     begin errors++; $display("FAIL edge_qn got %h want %h t=%0t", ife.q_n, ~e.qe, $time); end
      if (ife.changed !== e.chg) begin errors++; $display("FAIL edge_changed got %b want %b t=%0t", ife.changed, e.chg, $time); end
      if (ife.cnt_out !== e.cnt) begin errors++; $display("FAIL edge_cnt got %0d want %0d t=%0t", ife.cnt_out, e.cnt, $time); end
      if (ifl.q !== e.ql)        begin errors++; $display("FAIL latch_q got %h want %h t=%0t", ifl.q, e.ql, $time); end
      if (ifl.q_n !== ~e.ql)     begin errors++; $display("FAIL latch_qn got %h want %h t=%0t", ifl.q_n, ~e.ql, $time); end
      if (ifl.changed !== e.chg) begin errors++; $display("FAIL latch_changed got %b want %b t=%0t", ifl.changed, e.chg, $time); end
      if (ifl.cnt_out !== e.cnt) begin errors++; $display("FAIL latch_cnt got %0d want %0d t=%0t", ifl.cnt_out, e.cnt, $time); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(); cycle();
      checks += 5;
      if (ife.q !== '0)         begin errors++; $display("FAIL reset_q got %h want 0", ife.q); end
      if (ife.q_n !== 16'hFFFF) begin errors++; $display("FAIL reset_qn got %h want ffff", ife.q_n); end
      if (ife.changed !== '0)   begin errors++; $display("FAIL reset_changed got %b want 0", ife.changed); end
      if (ife.cnt_out !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ife.cnt_out); end
      if (if3.cnt_out !== 8'd0) begin errors++; $display("FAIL reset_cnt3 got %0d want 0", if3.cnt_out); end
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_edge_load();
      r_sel = 2'd1;
      r_d = 16'h00A0; r_en = 4'b0010;
      cycle();
      checks += 4;
      if (ife.q[7:4] !== 4'hA)   begin errors++; $display("FAIL edge_load_q got %h want a", ife.q[7:4]); end
      if (ife.q_n[7:4] !== 4'h5) begin errors++; $display("FAIL edge_load_qn got %h want 5", ife.q_n[7:4]); end
      if (ife.changed !== 4'b0010) begin errors++; $display("FAIL edge_load_pulse got %b want 0010", ife.changed); end
      if (ife.cnt_out !== 8'd1)  begin errors++; $display("FAIL edge_load_cnt got %0d want 1", ife.cnt_out); end
      r_en = '0; r_d = 16'h0050;
      cycle();
      checks += 2;
      if (ife.changed !== 4'b0000) begin errors++; $display("FAIL edge_load_single got %b want 0000", ife.changed); end
      if (ife.q[7:4] !== 4'hA)     begin errors++; $display("FAIL edge_load_hold got %h want a", ife.q[7:4]); end
   endtask

   task automatic test_latch();
      r_en = 4'b0001; r_d = 16'h0003;
      #1;
      checks += 2;
      if (ifl.q[3:0] !== 4'h3) begin errors++; $display("FAIL latch_follow3 got %h want 3", ifl.q[3:0]); end
      if (ife.q[3:0] !== 4'h0) begin errors++; $display("FAIL edge_nopath got %h want 0", ife.q[3:0]); end
      r_d = 16'h000C;
      #1;
      checks += 1;
      if (ifl.q[3:0] !== 4'hC) begin errors++; $display("FAIL latch_followC got %h want c", ifl.q[3:0]); end
      cycle();
      r_en = '0; r_d = 16'h0001;
      #1;
      checks += 1;
      if (ifl.q[3:0] !== 4'hC) begin errors++; $display("FAIL latch_hold got %h want c", ifl.q[3:0]); end
      cycle();
   endtask

   task automatic test_clr_en();
      r_sel = 2'd2;
      r_en = 4'b0100; r_d = 16'h0700;
      cycle();
      r_en = '0;
      cycle();
      r_clr = 4'b0100; r_en = 4'b0100; r_d = 16'h0F00;
      #1;
      checks += 1;
      if (ifl.q[11:8] !== 4'h0) begin errors++; $display("FAIL clr_latch_now got %h want 0", ifl.q[11:8]); end
      cycle();
      checks += 3;
      if (ife.q[11:8] !== 4'h0)   begin errors++; $display("FAIL clr_wins got %h want 0", ife.q[11:8]); end
      if (ife.changed[2] !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b want 1", ife.changed[2]); end
      if (ife.cnt_out !== 8'd2)   begin errors++; $display("FAIL clr_cnt got %0d want 2", ife.cnt_out); end
      r_en = '0;
      cycle();
      checks += 1;
      if (ife.changed[2] !== 1'b0) begin errors++; $display("FAIL clr_zero_nopulse got %b want 0", ife.changed[2]); end
      r_clr = '0;
      cycle();
   endtask

   task automatic test_freeze();
      r_en = 4'hF; r_d = 16'h1234;
      cycle();
      r_freeze = 1'b1; r_d = 16'h9876;
      #1;
      checks += 1;
      if (ifl.q !== 16'h1234) begin errors++; $display("FAIL freeze_latch_shows_st got %h want 1234", ifl.q); end
      cycle(); cycle();
      checks += 1;
      if (ife.changed !== 4'b0000) begin errors++; $display("FAIL freeze_nopulse got %b want 0000", ife.changed); end
      r_clr = 4'b0001;
      cycle();
      checks += 1;
      if (ife.q !== 16'h1230) begin errors++; $display("FAIL freeze_clr got %h want 1230", ife.q); end
      r_clr = '0; r_freeze = 1'b0; r_en = '0;
      cycle();
   endtask

   task automatic test_back_to_back();
      r_sel = 2'd3;
      r_en = 4'b1000;
      for (int k = 0; k < 300; k++) begin
         r_d = (k % 2 == 0) ? 16'h5000 : 16'hA000;
         cycle();
      end
      checks += 2;
      if (ife.cnt_out !== 8'd255)  begin errors++; $display("FAIL saturate_cnt got %0d want 255", ife.cnt_out); end
      if (ife.changed[3] !== 1'b1) begin errors++; $display("FAIL saturate_pulse got %b want 1", ife.changed[3]); end
      r_en = '0;
      cycle();
   endtask

   task automatic test_rst_mid();
      r_en = 4'hF; r_d = 16'hBEEF;
      cycle();
      rst = 1'b1;
      #1;
      checks += 1;
      if (ifl.q !== 16'h0000) begin errors++; $display("FAIL rst_latch_now got %h want 0", ifl.q); end
      cycle();
      checks += 3;
      if (ife.q !== 16'h0000)   begin errors++; $display("FAIL rst_q got %h want 0", ife.q); end
      if (ife.q_n !== 16'hFFFF) begin errors++; $display("FAIL rst_qn got %h want ffff", ife.q_n); end
      if (ife.cnt_out !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", ife.cnt_out); end
      rst = 1'b0; r_en = '0;
      cycle();
   endtask

   task automatic test_sel_range();
      r3_d = 12'h600; r3_en = 3'b100;
      cycle();
      r3_en = '0;
      r3_sel = 2'd2;
      #1;
      checks += 1;
      if (if3.cnt_out !== 8'd1) begin errors++; $display("FAIL sel3_ch2 got %0d want 1", if3.cnt_out); end
      r3_sel = 2'd3;
      #1;
      checks += 1;
      if (if3.cnt_out !== 8'd0) begin errors++; $display("FAIL sel3_oob got %0d want 0", if3.cnt_out); end
   endtask

   initial begin
      for (int i = 0; i < int'(C); i++) begin
         m_st[i]  = '0;
         m_cnt[i] = 0;
      end
      test_reset();
      test_edge_load();
      test_latch();
      test_clr_en();
      test_freeze();
      test_back_to_back();
      test_rst_mid();
      test_sel_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
